// File: rtl/sobel_pkg.sv
// Shared encodings for the Sobel gradient stage.
// Mode and direction codes plus a width helper.
package sobel_pkg;

  typedef enum logic [1:0] {
    MODE_BIN    = 2'd0,
    MODE_MAG    = 2'd1,
    MODE_MAGTHR = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    DIR_0   = 2'd0,
    DIR_45  = 2'd1,
    DIR_90  = 2'd2,
    DIR_135 = 2'd3
  } dir_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two cascaded line memories: tap1 is the previous line,
// tap0 the line before it. Reads return pre-write data.
module sobel_line_buffer #(
  parameter int DW    = 8,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] tap1,
  output logic [DW-1:0] tap0
);

  logic [DW-1:0] ram1 [DEPTH];
  logic [DW-1:0] ram0 [DEPTH];

  assign tap1 = ram1[addr];
  assign tap0 = ram0[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      ram1[addr] <= din;
      ram0[addr] <= ram1[addr];
    end
  end

endmodule

// File: rtl/sobel_gradient.sv
// Sobel edge stage: 3x3 window, |Gx|+|Gy| magnitude, direction,
// per-frame config latch, border suppression and overflow flag.
module sobel_gradient
  import sobel_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_WIDTH     = 1024,
  parameter int THRESHOLD_DEF = 128,
  parameter int MODE_DEF      = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  din_hsync,
  input  logic                  din_vsync,
  input  logic [DATA_WIDTH+2:0] cfg_threshold,
  input  logic [1:0]            cfg_mode,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            dout_dir,
  output logic                  dout_valid,
  output logic                  dout_hsync,
  output logic                  dout_vsync,
  output logic                  line_overflow
);

  localparam int DW   = DATA_WIDTH;
  localparam int GW   = DW + 2;
  localparam int MW   = DW + 3;
  localparam int CW   = clog2(MAX_WIDTH + 1);
  localparam int AW   = clog2(MAX_WIDTH);
  localparam int MAXV = (1 << DW) - 1;

  logic                    vs_q, hs_q;
  logic [CW-1:0]           col_q, col_d;
  logic [CW-1:0]           row_q, row_d;
  logic [MW-1:0]           thr_q, thr_d;
  logic [1:0]              mode_q, mode_d;
  logic                    ovf_q, ovf_d;
  logic [2:0][2:0][DW-1:0] w_q, w_d;
  logic                    v1_q, hs1_q, vs1_q, bd1_q, bd1_d;
  logic [GW-1:0]           gx_q, gx_d, gy_q, gy_d;
  logic                    gxn_q, gxn_d, gyn_q, gyn_d;
  logic                    v2_q, hs2_q, vs2_q, bd2_q;
  logic [DW-1:0]           dout_q, dout_d;
  logic [1:0]              dir_q, dir_d;
  logic                    v3_q, hs3_q, vs3_q;

  logic          frame_start, accept, at_max, wr;
  logic [DW-1:0] tap1, tap0;

  sobel_line_buffer #(
    .DW   (DW),
    .DEPTH(MAX_WIDTH),
    .AW   (AW)
  ) u_lb (
    .clk (clk),
    .we  (wr),
    .addr(col_q[AW-1:0]),
    .din (din),
    .tap1(tap1),
    .tap0(tap0)
  );

  always_comb begin
    frame_start = din_vsync & ~vs_q;
    accept      = din_valid & din_hsync & din_vsync;
    at_max      = col_q == CW'(MAX_WIDTH);
    wr          = accept & ~at_max;
    col_d  = col_q;
    row_d  = row_q;
    thr_d  = thr_q;
    mode_d = mode_q;
    ovf_d  = ovf_q;
    w_d    = w_q;
    if (frame_start) begin
      thr_d  = cfg_threshold;
      mode_d = cfg_mode;
      ovf_d  = 1'b0;
    end
    if (accept && at_max) ovf_d = 1'b1;
    if (!din_hsync) col_d = '0;
    else if (wr) col_d = col_q + 1'b1;
    if (!din_vsync || frame_start) row_d = '0;
    else if (hs_q && !din_hsync && col_q != '0 && row_q != '1)
      row_d = row_q + 1'b1;
    // col2 is the newest column: {line-2, line-1, din}
    if (!din_hsync || !din_vsync) begin
      w_d = '0;
    end else if (wr) begin
      for (int r = 0; r < 3; r++) begin
        w_d[r][0] = w_q[r][1];
        w_d[r][1] = w_q[r][2];
      end
      w_d[0][2] = tap0;
      w_d[1][2] = tap1;
      w_d[2][2] = din;
    end
    bd1_d = ~accept | at_max | (row_q < CW'(2)) | (col_q < CW'(2));
  end

  logic [GW-1:0] sp, sn, st, sb;

  always_comb begin
    sp = GW'(w_q[0][2]) + GW'({w_q[1][2], 1'b0}) + GW'(w_q[2][2]);
    sn = GW'(w_q[0][0]) + GW'({w_q[1][0], 1'b0}) + GW'(w_q[2][0]);
    st = GW'(w_q[0][0]) + GW'({w_q[0][1], 1'b0}) + GW'(w_q[0][2]);
    sb = GW'(w_q[2][0]) + GW'({w_q[2][1], 1'b0}) + GW'(w_q[2][2]);
    gxn_d = sp < sn;
    gyn_d = st < sb;
    gx_d  = gxn_d ? sn - sp : sp - sn;
    gy_d  = gyn_d ? sb - st : st - sb;
  end

  logic [MW-1:0] mag;
  logic [DW-1:0] sat, res;
  logic          over;

  always_comb begin
    mag  = MW'(gx_q) + MW'(gy_q);
    sat  = (mag > MW'(MAXV)) ? '1 : mag[DW-1:0];
    over = mag > thr_q;
    res  = '0;
    unique case (1'b1)
      mode_q == MODE_MAG:    res = sat;
      mode_q == MODE_MAGTHR: res = over ? sat : '0;
      default:               res = over ? '1 : '0;
    endcase
    if ({gy_q, 1'b0} <= MW'(gx_q)) dir_d = DIR_0;
    else if ({gx_q, 1'b0} <= MW'(gy_q)) dir_d = DIR_90;
    else if (gxn_q == gyn_q) dir_d = DIR_45;
    else dir_d = DIR_135;
    if (bd2_q) begin
      res   = '0;
      dir_d = DIR_0;
    end
    dout_d = dout_q;
    if (!v2_q) dir_d = dir_q;
    else dout_d = res;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_q   <= 1'b0;
      hs_q   <= 1'b0;
      col_q  <= '0;
      row_q  <= '0;
      thr_q  <= MW'(THRESHOLD_DEF);
      mode_q <= 2'(MODE_DEF);
      ovf_q  <= 1'b0;
      w_q    <= '0;
      v1_q   <= 1'b0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      bd1_q  <= 1'b0;
      gx_q   <= '0;
      gy_q   <= '0;
      gxn_q  <= 1'b0;
      gyn_q  <= 1'b0;
      v2_q   <= 1'b0;
      hs2_q  <= 1'b0;
      vs2_q  <= 1'b0;
      bd2_q  <= 1'b0;
      dout_q <= '0;
      dir_q  <= '0;
      v3_q   <= 1'b0;
      hs3_q  <= 1'b0;
      vs3_q  <= 1'b0;
    end else begin
      vs_q   <= din_vsync;
      hs_q   <= din_hsync;
      col_q  <= col_d;
      row_q  <= row_d;
      thr_q  <= thr_d;
      mode_q <= mode_d;
      ovf_q  <= ovf_d;
      w_q    <= w_d;
      v1_q   <= din_valid;
      hs1_q  <= din_hsync;
      vs1_q  <= din_vsync;
      bd1_q  <= bd1_d;
      gx_q   <= gx_d;
      gy_q   <= gy_d;
      gxn_q  <= gxn_d;
      gyn_q  <= gyn_d;
      v2_q   <= v1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      bd2_q  <= bd1_q;
      dout_q <= dout_d;
      dir_q  <= dir_d;
      v3_q   <= v2_q;
      hs3_q  <= hs2_q;
      vs3_q  <= vs2_q;
    end
  end

  assign dout          = dout_q;
  assign dout_dir      = dir_q;
  assign dout_valid    = v3_q;
  assign dout_hsync    = hs3_q;
  assign dout_vsync    = vs3_q;
  assign line_overflow = ovf_q;

endmodule
